// File: rtl/inference_sequencer_if.sv
// Bundle of SPI receive, image-buffer write and BNN control/result signals
// around the inference sequencer. master = sequencer, slave = its surroundings.
interface inference_sequencer_if;
    logic [7:0] spi_rx_data;
    logic       spi_byte_valid;
    logic       byte_taken;
    logic       buffer_write_request;
    logic       buffer_write_ready;
    logic [7:0] buffer_write_data;
    logic       buffer_full;
    logic       buffer_empty;
    logic       clear;
    logic       bnn_enable;
    logic       result_ready;
    logic [3:0] result_out;
    logic [3:0] result_latched;
    logic       result_valid;
    logic [3:0] status_code;

    modport master (
        input  spi_rx_data, spi_byte_valid, buffer_write_ready, buffer_full,
               buffer_empty, result_ready, result_out,
        output byte_taken, buffer_write_request, buffer_write_data, clear,
               bnn_enable, result_latched, result_valid, status_code
    );

    modport slave (
        output spi_rx_data, spi_byte_valid, buffer_write_ready, buffer_full,
               buffer_empty, result_ready, result_out,
        input  byte_taken, buffer_write_request, buffer_write_data, clear,
               bnn_enable, result_latched, result_valid, status_code
    );
endinterface

// File: rtl/inference_sequencer.sv
// One OCR inference job: command decode, single-frame buffer load, BNN run, result latch.
// Optional RUN watchdog enabled by defining INFERENCE_SEQ_TIMEOUT_EN.
module inference_sequencer #(
    parameter int         IMG_BYTES      = 113,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] CMD_LOAD       = 8'hA5,
    parameter logic [7:0] CMD_CLEAR      = 8'hC3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inference_sequencer_if.master io_seq
);

    // State encoding doubles as the externally visible status code.
    typedef enum logic [3:0] {
        S_IDLE         = 4'h0,
        S_LOAD         = 4'h1,
        S_RUN          = 4'h2,
        S_DONE         = 4'h3,
        S_CLEAR        = 4'h4,
`ifdef INFERENCE_SEQ_TIMEOUT_EN
        S_ERR_TIMEOUT  = 4'hE,
`endif
        S_ERR_OVERFLOW = 4'hF
    } state_t;

    localparam int               CNT_W    = $clog2(IMG_BYTES + 1);
    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_BYTES);

    state_t           r_state;
    logic [CNT_W-1:0] r_byte_cnt;
    logic             r_byte_taken;
    logic             r_write_req;
    logic [7:0]       r_write_data;
    logic             r_clear;
    logic             r_bnn_enable;
    logic [3:0]       r_result_latched;
    logic             r_result_valid;

`ifdef INFERENCE_SEQ_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] r_run_timer;
`endif

    // A byte still held by SPI in the cycle of our byte_taken pulse is the one
    // just consumed, so it must not be accepted a second time.
    logic w_byte_avail;
    logic w_is_clear;
    logic w_is_load;

    assign w_byte_avail = io_seq.spi_byte_valid && !r_byte_taken;
    assign w_is_clear   = (io_seq.spi_rx_data == CMD_CLEAR);
    assign w_is_load    = (io_seq.spi_rx_data == CMD_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_byte_cnt       <= '0;
            r_byte_taken     <= 1'b0;
            r_write_req      <= 1'b0;
            r_write_data     <= 8'h00;
            r_clear          <= 1'b0;
            r_bnn_enable     <= 1'b0;
            r_result_latched <= 4'h0;
            r_result_valid   <= 1'b0;
`ifdef INFERENCE_SEQ_TIMEOUT_EN
            r_run_timer      <= '0;
`endif
        end else begin
            r_byte_taken <= 1'b0;
            r_clear      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_byte_avail) begin
                        r_byte_taken <= 1'b1;
                        if (w_is_load) begin
                            r_state    <= S_LOAD;
                            r_byte_cnt <= '0;
                        end else if (w_is_clear) begin
                            r_state          <= S_CLEAR;
                            r_clear          <= 1'b1;
                            r_result_valid   <= 1'b0;
                            r_result_latched <= 4'h0;
                        end
                    end
                end

                S_LOAD: begin
                    if (io_seq.buffer_full) begin
                        if (r_byte_cnt == IMG_LAST) begin
                            r_state      <= S_RUN;
                            r_bnn_enable <= 1'b1;
`ifdef INFERENCE_SEQ_TIMEOUT_EN
                            r_run_timer  <= '0;
`endif
                        end else begin
                            r_state     <= S_ERR_OVERFLOW;
                            r_write_req <= 1'b0;
                        end
                    end else if (r_write_req) begin
                        if (io_seq.buffer_write_ready) begin
                            r_write_req <= 1'b0;
                            r_byte_cnt  <= r_byte_cnt + 1'b1;
                        end
                    end else if (w_byte_avail && (r_byte_cnt != IMG_LAST)) begin
                        // Inside a frame every byte is image data, CMD_CLEAR included.
                        r_write_data <= io_seq.spi_rx_data;
                        r_write_req  <= 1'b1;
                        r_byte_taken <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (io_seq.result_ready) begin
                        r_state          <= S_DONE;
                        r_bnn_enable     <= 1'b0;
                        r_result_latched <= io_seq.result_out;
                        r_result_valid   <= 1'b1;
                    end
`ifdef INFERENCE_SEQ_TIMEOUT_EN
                    else if (r_run_timer == TMR_LAST) begin
                        r_state      <= S_ERR_TIMEOUT;
                        r_bnn_enable <= 1'b0;
                    end else begin
                        r_run_timer <= r_run_timer + 1'b1;
                    end
`endif
                end

`ifdef INFERENCE_SEQ_TIMEOUT_EN
                S_DONE, S_ERR_TIMEOUT, S_ERR_OVERFLOW: begin
`else
                S_DONE, S_ERR_OVERFLOW: begin
`endif
                    if (w_byte_avail) begin
                        r_byte_taken <= 1'b1;
                        if (w_is_clear) begin
                            r_state          <= S_CLEAR;
                            r_clear          <= 1'b1;
                            r_result_valid   <= 1'b0;
                            r_result_latched <= 4'h0;
                        end
                    end
                end

                S_CLEAR: begin
                    r_state    <= S_IDLE;
                    r_byte_cnt <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_seq.byte_taken           = r_byte_taken;
    assign io_seq.buffer_write_request = r_write_req;
    assign io_seq.buffer_write_data    = r_write_data;
    assign io_seq.clear                = r_clear;
    assign io_seq.bnn_enable           = r_bnn_enable;
    assign io_seq.result_latched       = r_result_latched;
    assign io_seq.result_valid         = r_result_valid;
    assign io_seq.status_code          = r_state;

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer: random frames, random backpressure,
// overflow, watchdog and reset scenarios against a behavioural buffer/SPI model.
module tb_inference_sequencer;
    localparam int IMG = 113;
    localparam int TO  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inference_sequencer_if bus ();

    inference_sequencer #(
        .IMG_BYTES      (IMG),
        .TIMEOUT_CYCLES (TO),
        .CMD_LOAD       (8'hA5),
        .CMD_CLEAR      (8'hC3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_seq (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Image buffer model: records every accepted write, full at IMG bytes.
    logic [7:0] wr_q[$];
    int  wr_cnt     = 0;
    bit  force_full = 1'b0;
    bit  rand_ready = 1'b0;
    bit  ready_lvl  = 1'b1;
    bit  rnd_bit    = 1'b1;
    int  taken_cnt  = 0;
    int  clear_cnt  = 0;

    assign bus.buffer_full        = force_full || (wr_cnt >= IMG);
    assign bus.buffer_empty       = (wr_cnt == 0);
    assign bus.buffer_write_ready = rand_ready ? rnd_bit : ready_lvl;

    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            wr_cnt <= 0;
            wr_q.delete();
        end else if (bus.buffer_write_request && bus.buffer_write_ready) begin
            wr_cnt <= wr_cnt + 1;
            wr_q.push_back(bus.buffer_write_data);
        end
        if (bus.byte_taken) taken_cnt <= taken_cnt + 1;
        if (bus.clear)      clear_cnt <= clear_cnt + 1;
    end

    // SPI source: hold the byte until a byte_taken pulse is observed.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.spi_rx_data    = b;
        bus.spi_byte_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.byte_taken === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.spi_byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] data[$], output int lost);
        bit ok;
        lost = 0;
        foreach (data[i]) begin
            send_byte(data[i], ok);
            if (!ok) lost++;
        end
    endtask

    task automatic wait_status(input logic [3:0] s, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.status_code === s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic rand_frame(output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < IMG; i++) q.push_back(8'($urandom));
    endtask

    task automatic load_and_run(output bit ok);
        logic [7:0] q[$];
        int lost;
        bit ok_a;
        rand_frame(q);
        send_byte(8'hA5, ok_a);
        send_bytes(q, lost);
        wait_status(4'h2, 40, ok);
        ok = ok && ok_a && (lost == 0);
    endtask

    task automatic finish_job(input logic [3:0] r);
        bit ok;
        bus.result_out   = r;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        send_byte(8'hC3, ok);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.status_code !== 4'h0) begin
            failures++; $display("FAIL reset_status: got %0h expected 0", bus.status_code);
        end
        checks++;
        if ({bus.byte_taken, bus.buffer_write_request, bus.buffer_write_data, bus.clear,
             bus.bnn_enable, bus.result_latched, bus.result_valid} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs: got taken=%b req=%b data=%0h clr=%b en=%b lat=%0h val=%b expected all 0",
                     bus.byte_taken, bus.buffer_write_request, bus.buffer_write_data, bus.clear,
                     bus.bnn_enable, bus.result_latched, bus.result_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: status=%0h", bus.status_code);
    endtask

    task automatic test_frame_load();
        logic [7:0] q[$];
        int lost, t0, bad_idx, en_bad;
        bit ok, run_ok;
        for (int i = 0; i < IMG; i++) q.push_back(8'(i));
        t0 = taken_cnt;
        send_byte(8'hA5, ok);
        checks++;
        if (!ok || bus.status_code !== 4'h1) begin
            failures++; $display("FAIL load_cmd: got taken=%b status=%0h expected 1/1", ok, bus.status_code);
        end
        send_bytes(q, lost);
        run_ok = 1'b0;
        en_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.bnn_enable !== (bus.status_code == 4'h2)) en_bad++;
            if (bus.status_code === 4'h2) begin run_ok = 1'b1; break; end
            if (bus.status_code !== 4'h1) break;
            @(negedge clk);
        end
        checks++;
        if (!run_ok || lost != 0) begin
            failures++; $display("FAIL run_entry: got status=%0h lost=%0d expected 2/0", bus.status_code, lost);
        end
        checks++;
        if (en_bad != 0 || bus.bnn_enable !== 1'b1) begin
            failures++; $display("FAIL bnn_enable_track: got bad=%0d en=%b expected 0/1", en_bad, bus.bnn_enable);
        end
        checks++;
        if (wr_q.size() != IMG) begin
            failures++; $display("FAIL write_count: got %0d expected %0d", wr_q.size(), IMG);
        end
        bad_idx = -1;
        for (int i = 0; i < IMG && i < wr_q.size(); i++)
            if (wr_q[i] !== q[i] && bad_idx < 0) bad_idx = i;
        checks++;
        if (bad_idx >= 0) begin
            failures++; $display("FAIL write_data: idx %0d got %0h expected %0h", bad_idx, wr_q[bad_idx], q[bad_idx]);
        end
        checks++;
        if (taken_cnt - t0 != IMG + 1) begin
            failures++; $display("FAIL taken_pulses: got %0d expected %0d", taken_cnt - t0, IMG + 1);
        end
        $display("frame_load: writes=%0d taken=%0d status=%0h", wr_q.size(), taken_cnt - t0, bus.status_code);
    endtask

    task automatic test_result_latch();
        logic [7:0] p;
        logic [3:0] r;
        int t0, c0, stray;
        bit ok;
        p = 8'($urandom_range(0, 8'h9F));
        r = 4'($urandom_range(0, 9));
        t0 = taken_cnt;
        stray = 0;
        bus.spi_rx_data    = p;
        bus.spi_byte_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.byte_taken !== 1'b0 || bus.status_code !== 4'h2) stray++;
        end
        checks++;
        if (stray != 0 || taken_cnt != t0) begin
            failures++; $display("FAIL run_holds_byte: got stray=%0d taken=%0d expected 0/0", stray, taken_cnt - t0);
        end
        bus.result_out   = r;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.result_out   = 4'($urandom_range(0, 9));
        checks++;
        if ({bus.status_code, bus.result_latched, bus.result_valid, bus.bnn_enable} !== {4'h3, r, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL result_latch: got st=%0h lat=%0d val=%b en=%b expected 3/%0d/1/0",
                     bus.status_code, bus.result_latched, bus.result_valid, bus.bnn_enable, r);
        end
        send_byte(p, ok);
        checks++;
        if (!ok || bus.status_code !== 4'h3 || bus.result_latched !== r) begin
            failures++; $display("FAIL done_drop: got taken=%b st=%0h lat=%0d expected 1/3/%0d", ok, bus.status_code, bus.result_latched, r);
        end
        c0 = clear_cnt;
        send_byte(8'hC3, ok);
        checks++;
        if (!ok || {bus.status_code, bus.clear, bus.result_valid, bus.result_latched} !== {4'h4, 1'b1, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL clear_state: got st=%0h clr=%b val=%b lat=%0d expected 4/1/0/0",
                     bus.status_code, bus.clear, bus.result_valid, bus.result_latched);
        end
        @(negedge clk);
        checks++;
        if (bus.status_code !== 4'h0 || bus.clear !== 1'b0 || clear_cnt - c0 != 1) begin
            failures++; $display("FAIL clear_once: got st=%0h clr=%b pulses=%0d expected 0/0/1", bus.status_code, bus.clear, clear_cnt - c0);
        end
        $display("result_latch: class=%0d status=%0h", r, bus.status_code);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] part[$];
        int lost, lost2, stall_bad, bad_idx;
        bit ok, run_ok;
        rand_frame(q);
        ready_lvl = 1'b1;
        send_byte(8'hA5, ok);
        part = q[0:9];
        send_bytes(part, lost);
        @(negedge clk);
        ready_lvl = 1'b0;
        send_byte(q[10], ok);
        if (!ok) lost++;
        bus.spi_rx_data    = q[11];
        bus.spi_byte_valid = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.buffer_write_request !== 1'b1 || bus.buffer_write_data !== q[10] ||
                bus.byte_taken !== 1'b0 || wr_cnt != 10) stall_bad++;
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL backpressure: got bad=%0d req=%b data=%0h writes=%0d expected 0/1/%0h/10",
                     stall_bad, bus.buffer_write_request, bus.buffer_write_data, wr_cnt, q[10]);
        end
        ready_lvl  = 1'b1;
        rand_ready = 1'b1;
        part = q[11:IMG-1];
        send_bytes(part, lost2);
        wait_status(4'h2, 80, run_ok);
        rand_ready = 1'b0;
        checks++;
        if (!run_ok || lost + lost2 != 0) begin
            failures++; $display("FAIL bp_run_entry: got status=%0h lost=%0d expected 2/0", bus.status_code, lost + lost2);
        end
        bad_idx = (wr_q.size() == IMG) ? -1 : wr_q.size();
        for (int i = 0; i < IMG && i < wr_q.size(); i++)
            if (wr_q[i] !== q[i] && bad_idx < 0) bad_idx = i;
        checks++;
        if (bad_idx >= 0) begin
            failures++; $display("FAIL bp_write_data: first bad index %0d of %0d writes expected none", bad_idx, wr_q.size());
        end
        finish_job(4'($urandom_range(0, 9)));
        checks++;
        if (bus.status_code !== 4'h0) begin
            failures++; $display("FAIL bp_return_idle: got %0h expected 0", bus.status_code);
        end
        $display("back_to_back: writes=%0d status=%0h", wr_q.size(), bus.status_code);
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        int lost;
        bit ok;
        rand_frame(q);
        q = q[0:49];
        send_byte(8'hA5, ok);
        send_bytes(q, lost);
        @(negedge clk);
        force_full = 1'b1;
        wait_status(4'hF, 5, ok);
        checks++;
        if (!ok || bus.buffer_write_request !== 1'b0 || bus.bnn_enable !== 1'b0 || lost != 0) begin
            failures++; $display("FAIL overflow: got st=%0h req=%b en=%b lost=%0d expected F/0/0/0",
                                 bus.status_code, bus.buffer_write_request, bus.bnn_enable, lost);
        end
        send_byte(8'hA5, ok);
        checks++;
        if (!ok || bus.status_code !== 4'hF) begin
            failures++; $display("FAIL overflow_sticky: got taken=%b st=%0h expected 1/F", ok, bus.status_code);
        end
        send_byte(8'hC3, ok);
        force_full = 1'b0;
        checks++;
        if (!ok || bus.status_code !== 4'h4 || bus.clear !== 1'b1) begin
            failures++; $display("FAIL overflow_clear: got st=%0h clr=%b expected 4/1", bus.status_code, bus.clear);
        end
        @(negedge clk);
        checks++;
        if (bus.status_code !== 4'h0 || bus.clear !== 1'b0) begin
            failures++; $display("FAIL overflow_idle: got st=%0h clr=%b expected 0/0", bus.status_code, bus.clear);
        end
        $display("overflow: status=%0h", bus.status_code);
    endtask

    task automatic test_timeout();
        bit ok;
        int left;
        load_and_run(ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL to_run_entry: got status=%0h expected 2", bus.status_code);
        end
`ifdef INFERENCE_SEQ_TIMEOUT_EN
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (bus.status_code !== 4'h2) begin
            failures++; $display("FAIL timeout_early: got %0h expected 2", bus.status_code);
        end
        @(negedge clk);
        checks++;
        if (bus.status_code !== 4'hE || bus.bnn_enable !== 1'b0) begin
            failures++; $display("FAIL timeout: got st=%0h en=%b expected E/0", bus.status_code, bus.bnn_enable);
        end
        send_byte(8'hC3, ok);
        @(negedge clk);
        load_and_run(ok);
        repeat (TO - 1) @(negedge clk);
        bus.result_out   = 4'h5;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        checks++;
        if (bus.status_code !== 4'h3 || bus.result_latched !== 4'h5) begin
            failures++; $display("FAIL result_beats_timeout: got st=%0h lat=%0d expected 3/5", bus.status_code, bus.result_latched);
        end
        send_byte(8'hC3, ok);
        @(negedge clk);
`else
        left = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            @(negedge clk);
            if (bus.status_code !== 4'h2 || bus.bnn_enable !== 1'b1) left++;
        end
        checks++;
        if (left != 0) begin
            failures++; $display("FAIL no_timeout: got %0d cycles off RUN, status=%0h expected 0/2", left, bus.status_code);
        end
        finish_job(4'h1);
`endif
        checks++;
        if (bus.status_code !== 4'h0) begin
            failures++; $display("FAIL to_return_idle: got %0h expected 0", bus.status_code);
        end
        $display("timeout: status=%0h", bus.status_code);
    endtask

    task automatic test_reset_in_load();
        logic [7:0] q[$];
        int lost, c0;
        bit ok;
        rand_frame(q);
        q = q[0:19];
        c0 = clear_cnt;
        send_byte(8'hA5, ok);
        send_bytes(q, lost);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.status_code, bus.byte_taken, bus.buffer_write_request, bus.buffer_write_data, bus.clear,
             bus.bnn_enable, bus.result_latched, bus.result_valid} !== 21'h0) begin
            failures++; $display("FAIL reset_mid_load: got st=%0h req=%b data=%0h expected all 0",
                                 bus.status_code, bus.buffer_write_request, bus.buffer_write_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h11, ok);
        @(negedge clk);
        checks++;
        if (!ok || bus.status_code !== 4'h0 || clear_cnt != c0 || bus.buffer_write_request !== 1'b0) begin
            failures++; $display("FAIL reset_then_unknown: got taken=%b st=%0h clears=%0d req=%b expected 1/0/0/0",
                                 ok, bus.status_code, clear_cnt - c0, bus.buffer_write_request);
        end
        $display("reset_in_load: status=%0h", bus.status_code);
    endtask

    initial begin
        bus.spi_rx_data    = 8'h00;
        bus.spi_byte_valid = 1'b0;
        bus.result_ready   = 1'b0;
        bus.result_out     = 4'h0;
        test_reset();
        test_frame_load();
        test_result_latch();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_reset_in_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end
endmodule
